// File: rtl/ddr_arbiter.sv
// ddr_arbiter: two-requester arbiter in front of a MIG-style DDR user interface.
//
// A write requester and a read requester each ask for a burst of len beats
// starting at addr. When both ask at once in IDLE, the side that did not win
// last time is granted (round-robin). The granted burst runs until it completes.
// New grants are only issued when calibration is done.
//
// Ports
//   ui_clk, ui_rst_n        clock (rising edge), asynchronous active-low reset
//   init_calib_complete     MIG calibration done; gates new grants only
//   wr_req/addr/len         write request; wr_grant held for the burst,
//                           wr_done pulses once after the last accepted beat
//   wr_data_rd, wr_data     FWFT FIFO pop and the write beat at its head
//   rd_req/addr/len         read request; rd_grant held for the burst,
//                           rd_done pulses together with the last rd_data_vld
//   rd_data, rd_data_vld    returned read beats, one cycle after the MIG
//   app_*                   MIG command, write-data and read-data channels
//   state_dbg               current FSM state (IDLE=0, WR=1, RD_CMD=2, RD_WAIT=3)
//
// Handshake: a MIG command is accepted on a cycle with app_en=1 and app_rdy=1.
// A write beat additionally needs app_wdf_rdy=1. In WR, command and data are
// issued together, so app_en/app_wdf_wren/app_wdf_end/wr_data_rd are all the
// same combinational term app_rdy & app_wdf_rdy.
module ddr_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 8
) (
  input  logic              ui_clk,
  input  logic              ui_rst_n,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_grant,
  output logic              wr_done,
  output logic              wr_data_rd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_grant,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t            state;
  logic              last_rd;   // 1 when the last grant went to the reader
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;  // accepted write beats or read commands
  logic [LEN_W-1:0]  ret_cnt;   // returned read beats

  logic              wr_ok;
  logic              rd_ok;
  logic              pick_wr;
  logic              wr_beat;
  logic              rd_cmd_acc;
  logic              rd_ret;
  logic [LEN_W-1:0]  beat_nxt;
  logic [LEN_W-1:0]  ret_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // Zero-length requests are treated as no request at all.
  assign wr_ok   = wr_req && (wr_len != '0);
  assign rd_ok   = rd_req && (rd_len != '0);
  // On a tie the writer wins only if the reader had the last grant.
  assign pick_wr = wr_ok && (!rd_ok || last_rd);

  assign wr_beat    = (state == WR) && app_rdy && app_wdf_rdy;
  assign rd_cmd_acc = (state == RD_CMD) && app_rdy;
  // Read data is only accepted while a read burst is active; anything else
  // (e.g. leftovers from a burst cut short by reset) is dropped.
  assign rd_ret     = ((state == RD_CMD) || (state == RD_WAIT)) && app_rd_data_valid;

  assign beat_nxt = beat_cnt + LEN_W'(1);
  assign ret_nxt  = ret_cnt + LEN_W'(1);
  // Wraps naturally at 2^ADDR_W.
  assign addr_nxt = app_addr + ADDR_W'(ADDR_STEP);

  assign app_en       = wr_beat || (state == RD_CMD);
  assign app_wdf_wren = wr_beat;
  assign app_wdf_end  = wr_beat;
  assign wr_data_rd   = wr_beat;
  assign app_wdf_data = (state == WR) ? wr_data : '0;
  assign state_dbg    = state;

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state       <= IDLE;
      last_rd     <= 1'b1;
      len_q       <= '0;
      beat_cnt    <= '0;
      ret_cnt     <= '0;
      app_addr    <= '0;
      app_cmd     <= 3'b000;
      wr_grant    <= 1'b0;
      rd_grant    <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      rd_data_vld <= 1'b0;

      if (rd_ret) begin
        rd_data     <= app_rd_data;
        rd_data_vld <= 1'b1;
        ret_cnt     <= ret_nxt;
      end

      case (state)
        IDLE: begin
          if (init_calib_complete && (wr_ok || rd_ok)) begin
            beat_cnt <= '0;
            ret_cnt  <= '0;
            last_rd  <= !pick_wr;
            if (pick_wr) begin
              app_addr <= wr_addr;
              len_q    <= wr_len;
              app_cmd  <= 3'b000;
              wr_grant <= 1'b1;
              state    <= WR;
            end else begin
              app_addr <= rd_addr;
              len_q    <= rd_len;
              app_cmd  <= 3'b001;
              rd_grant <= 1'b1;
              state    <= RD_CMD;
            end
          end
        end

        WR: begin
          if (wr_beat) begin
            app_addr <= addr_nxt;
            beat_cnt <= beat_nxt;
            if (beat_nxt == len_q) begin
              wr_done  <= 1'b1;
              wr_grant <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        RD_CMD: begin
          if (rd_cmd_acc) begin
            app_addr <= addr_nxt;
            beat_cnt <= beat_nxt;
            if (beat_nxt == len_q) state <= RD_WAIT;
          end
          // Completion on the return side takes precedence over command issue.
          if (rd_ret && (ret_nxt == len_q)) begin
            rd_done  <= 1'b1;
            rd_grant <= 1'b0;
            state    <= IDLE;
          end
        end

        RD_WAIT: begin
          if (rd_ret && (ret_nxt == len_q)) begin
            rd_done  <= 1'b1;
            rd_grant <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Testbench for ddr_arbiter: directed scenarios; expected MIG commands, read
// beats and done pulses are queued by the drivers and checked by a monitor.
module tb_ddr_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 8;
  localparam int EW     = 3 + 3 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              calib;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_grant;
  logic              wr_done;
  logic              wr_data_rd;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_grant;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic [1:0]        state_dbg;

  ddr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_STEP(8)
  ) dut (
    .ui_clk(clk), .ui_rst_n(rst_n), .init_calib_complete(calib),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_grant(wr_grant), .wr_done(wr_done),
    .wr_data_rd(wr_data_rd), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_grant(rd_grant), .rd_done(rd_done),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]       exp_cmd_q[$];   // {wren,end,pop, cmd, addr, wdata}
  logic [DATA_W:0]     exp_rd_q[$];    // {rd_done, rd_data}
  logic [0:0]          exp_done_q[$];  // 0 = wr_done, 1 = rd_done
  logic [ADDR_W-1:0]   mig_addr_q[$];
  int unsigned         mig_due_q[$];
  int unsigned         cyc;
  int                  n_checks = 0;
  int                  n_fail   = 0;
  logic                prev_vld;
  logic [DATA_W-1:0]   prev_data;
  logic [EW-1:0]       obs;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {4{4'h5, a}} ^ {4{32'h1234_5678}};
  endfunction

  function automatic logic [EW-1:0] exp_w(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {3'b111, 3'b000, a, d};
  endfunction

  function automatic logic [EW-1:0] exp_r(input logic [ADDR_W-1:0] a);
    return {3'b000, 3'b001, a, {DATA_W{1'b0}}};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [EW-1:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic kind, input string name, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      cycles++;
      seen = kind ? rd_done : wr_done;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: done got 0 expected 1 within 200 cycles", name);
    end
  endtask

  // MIG read model: each accepted read command returns mem_word(addr)
  // two cycles later, in order, one beat per cycle at most.
  initial begin
    cyc = 0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mig_due_q.size() > 0 && mig_due_q[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = mem_word(mig_addr_q.pop_front());
        void'(mig_due_q.pop_front());
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (app_en && app_rdy) begin
        obs = {app_wdf_wren, app_wdf_end, wr_data_rd, app_cmd, app_addr,
               (app_cmd == 3'b000) ? app_wdf_data : {DATA_W{1'b0}}};
        if (app_cmd == 3'b001) begin
          mig_addr_q.push_back(app_addr);
          mig_due_q.push_back(cyc + 2);
        end
        if (exp_cmd_q.size() == 0) unexpected("cmd", obs);
        else check("cmd", obs, exp_cmd_q.pop_front());
      end
      if (wr_done) begin
        if (exp_done_q.size() == 0) unexpected("wr_done", 1);
        else check("done_order_wr", 1'b0, exp_done_q.pop_front());
      end
      if (rd_done) begin
        if (exp_done_q.size() == 0) unexpected("rd_done", 1);
        else check("done_order_rd", 1'b1, exp_done_q.pop_front());
      end
      if (rd_data_vld) begin
        if (exp_rd_q.size() == 0) unexpected("rd_beat", {rd_done, rd_data});
        else check("rd_beat", {rd_done, rd_data}, exp_rd_q.pop_front());
        check("rd_latency", {prev_vld, prev_data}, {1'b1, rd_data});
      end
    end
    prev_vld  = app_rd_data_valid;
    prev_data = app_rd_data;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cycles;
    logic seen;
    rst_n = 1'b0; calib = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_state",  state_dbg, 2'd0);
    check("rst_flags",  {wr_grant, rd_grant, wr_done, rd_done, rd_data_vld}, 0);
    check("rst_app",    {app_en, app_wdf_wren, app_wdf_end, wr_data_rd, app_cmd, app_addr}, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // Tie out of reset: write, read, write
    calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_addr = 28'h000_1000; wr_len = 8'd2; wr_data = 128'hAAAA_0001;
    rd_addr = 28'h000_2000; rd_len = 8'd2;
    exp_cmd_q.push_back(exp_w(28'h000_1000, 128'hAAAA_0001));
    exp_cmd_q.push_back(exp_w(28'h000_1008, 128'hAAAA_0001));
    exp_done_q.push_back(1'b0);
    exp_cmd_q.push_back(exp_r(28'h000_2000));
    exp_cmd_q.push_back(exp_r(28'h000_2008));
    exp_rd_q.push_back({1'b0, mem_word(28'h000_2000)});
    exp_rd_q.push_back({1'b1, mem_word(28'h000_2008)});
    exp_done_q.push_back(1'b1);
    exp_cmd_q.push_back(exp_w(28'h000_1000, 128'hAAAA_0001));
    exp_cmd_q.push_back(exp_w(28'h000_1008, 128'hAAAA_0001));
    exp_done_q.push_back(1'b0);
    wr_req = 1'b1; rd_req = 1'b1;
    wait_done(1'b0, "tie_wr1", cycles);
    wait_done(1'b1, "tie_rd",  cycles);
    wait_done(1'b0, "tie_wr2", cycles);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) tick();

    // Write burst, ready always high
    wr_addr = 28'h000_0100; wr_len = 8'd4; wr_data = 128'hBEEF_0004;
    exp_cmd_q.push_back(exp_w(28'h000_0100, 128'hBEEF_0004));
    exp_cmd_q.push_back(exp_w(28'h000_0108, 128'hBEEF_0004));
    exp_cmd_q.push_back(exp_w(28'h000_0110, 128'hBEEF_0004));
    exp_cmd_q.push_back(exp_w(28'h000_0118, 128'hBEEF_0004));
    exp_done_q.push_back(1'b0);
    wr_req = 1'b1;
    tick();
    check("wr_grant_next_cycle", {wr_grant, rd_grant}, 2'b10);
    wait_done(1'b0, "wr_burst", cycles);
    check("wr_burst_cycles", cycles, 4);
    wr_req = 1'b0;
    tick();
    check("wr_grant_released", wr_grant, 1'b0);

    // Read burst with app_rdy toggling
    rd_addr = 28'h000_0200; rd_len = 8'd3;
    exp_cmd_q.push_back(exp_r(28'h000_0200));
    exp_cmd_q.push_back(exp_r(28'h000_0208));
    exp_cmd_q.push_back(exp_r(28'h000_0210));
    exp_rd_q.push_back({1'b0, mem_word(28'h000_0200)});
    exp_rd_q.push_back({1'b0, mem_word(28'h000_0208)});
    exp_rd_q.push_back({1'b1, mem_word(28'h000_0210)});
    exp_done_q.push_back(1'b1);
    rd_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      app_rdy = ~app_rdy;
      seen = rd_done;
    end
    check("rd_toggle_done", seen, 1'b1);
    rd_req = 1'b0; app_rdy = 1'b1;
    repeat (3) tick();

    // Stall and address wrap; calibration drops mid-burst
    wr_addr = 28'hFFF_FFF8; wr_len = 8'd2; wr_data = 128'hC0DE_0002;
    exp_cmd_q.push_back(exp_w(28'hFFF_FFF8, 128'hC0DE_0002));
    exp_cmd_q.push_back(exp_w(28'h000_0000, 128'hC0DE_0002));
    exp_done_q.push_back(1'b0);
    wr_req = 1'b1;
    tick();
    tick();
    app_wdf_rdy = 1'b0; calib = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_beat", {app_en, app_wdf_wren, wr_data_rd, wr_grant, wr_done}, 5'b00010);
    end
    app_wdf_rdy = 1'b1;
    wait_done(1'b0, "stall_wrap", cycles);
    check("stall_wrap_cycles", cycles, 1);
    wr_req = 1'b0;
    tick();
    calib = 1'b1;

    // Calibration gating and zero-length request
    calib = 1'b0; wr_addr = 28'h000_0500; wr_len = 8'd4; wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("calib_gate", {wr_grant, rd_grant, app_en, state_dbg}, 0);
    end
    wr_req = 1'b0;
    tick();
    calib = 1'b1; rd_addr = 28'h000_0600; rd_len = 8'd0; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("len0_ignored", {wr_grant, rd_grant, app_en, state_dbg}, 0);
    end
    rd_req = 1'b0;
    tick();

    // Reset during RD_CMD after one of four commands
    app_rdy = 1'b1; rd_addr = 28'h000_0300; rd_len = 8'd4;
    exp_cmd_q.push_back(exp_r(28'h000_0300));
    rd_req = 1'b1;
    tick();
    tick();
    rst_n = 1'b0; rd_req = 1'b0;
    #1;
    check("rst_mid_flags", {state_dbg, wr_grant, rd_grant, wr_done, rd_done, rd_data_vld}, 0);
    check("rst_mid_app", {app_en, app_wdf_wren, app_wdf_end, wr_data_rd, app_cmd, app_addr}, 0);
    check("rst_mid_rd_data", rd_data, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", {state_dbg, rd_grant, rd_data_vld, rd_done}, 0);
    end
    rd_addr = 28'h000_0400; rd_len = 8'd1;
    exp_cmd_q.push_back(exp_r(28'h000_0400));
    exp_rd_q.push_back({1'b1, mem_word(28'h000_0400)});
    exp_done_q.push_back(1'b1);
    rd_req = 1'b1;
    tick();
    check("post_rst_grant", {rd_grant, state_dbg}, {1'b1, 2'd2});
    wait_done(1'b1, "post_rst_read", cycles);
    rd_req = 1'b0;

    repeat (10) tick();
    check("cmd_q_empty",  exp_cmd_q.size(), 0);
    check("rd_q_empty",   exp_rd_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
